// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares one combinational 32x32
// signed multiplier among NREQ requesters. Stage S1 holds the granted
// operands. Stage S2 holds the 64-bit product and drives the response channel.

// Combinational signed 32x32 -> 64 multiplier shared by all requesters.
module multiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;

    // Sign-extend both operands so the full 64-bit product is two's complement.
    assign a_ext = {{32{a[31]}}, a};
    assign b_ext = {{32{b[31]}}, b};
    assign p     = a_ext * b_ext;
endmodule

module mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [63:0]          rsp_result,
    output logic [31:0]          ops_count
);

    // Pipeline and arbitration state.
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_a_q, s1_a_d;
    logic [31:0]     s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s2_valid_q, s2_valid_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [63:0]     s2_result_q, s2_result_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     ops_count_q, ops_count_d;

    logic            s2_move;
    logic            s1_move;
    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] cand;
    logic [63:0]     mul_p;

    multiplier u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mul_p)
    );

    // Stage advance: S2 frees when empty or drained, S1 frees when S2 can take it.
    assign s2_move = !s2_valid_q || rsp_ready;
    assign s1_move = !s1_valid_q || s2_move;

    // Round-robin search starting at rr_ptr for the first valid requester.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Next-state logic for both stages, the pointer and the response counter.
    always_comb begin
        req_ready   = '0;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        s2_valid_d  = s2_valid_q;
        s2_id_d     = s2_id_q;
        s2_result_d = s2_result_q;
        rr_ptr_d    = rr_ptr_q;
        ops_count_d = ops_count_q;

        if (s1_move) begin
            s1_valid_d = grant_found;
            if (grant_found) begin
                req_ready[grant_id] = 1'b1;
                s1_a_d   = req_a[32*grant_id +: 32];
                s1_b_d   = req_b[32*grant_id +: 32];
                s1_id_d  = grant_id;
                rr_ptr_d = ID_W'((int'(grant_id) + 1) % NREQ);
            end
        end

        if (s2_move) begin
            s2_valid_d  = s1_valid_q;
            s2_id_d     = s1_id_q;
            s2_result_d = mul_p;
        end

        if (s2_valid_q && rsp_ready) begin
            ops_count_d = ops_count_q + 32'd1;
        end
    end

    // State registers; reset clears the pipeline, pointer and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too so rsp_id/rsp_result read zero after reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= '0;
            s2_result_q <= '0;
            rr_ptr_q    <= '0;
            ops_count_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_id_q     <= s2_id_d;
            s2_result_q <= s2_result_d;
            rr_ptr_q    <= rr_ptr_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_id     = s2_id_q;
    assign rsp_result = s2_result_q;
    assign ops_count  = ops_count_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed testbench for mul_arbiter: grant order, latency, fairness,
// backpressure, corner products, random products and mid-flight reset.
module tb_mul_arbiter;
    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [63:0]         rsp_result;
    logic [31:0]         ops_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] t2_a [4];
    logic [31:0] t2_b [4];
    logic [63:0] t2_p [4];

    mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .ops_count  (ops_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
        req_valid[k]       = 1'b1;
        req_a[32*k +: 32]  = a;
        req_b[32*k +: 32]  = b;
    endtask

    task automatic clr_req(input int k);
        req_valid[k] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        longint      ea, eb;
        logic [63:0] rexp;

        t2_a[0] = 32'd3;         t2_b[0] = 32'd5;         t2_p[0] = 64'd15;
        t2_a[1] = 32'hFFFFFFFC;  t2_b[1] = 32'd6;         t2_p[1] = 64'hFFFFFFFFFFFFFFE8;
        t2_a[2] = 32'd1000;      t2_b[2] = 32'd1000;      t2_p[2] = 64'd1000000;
        t2_a[3] = 32'hFFFFFFF9;  t2_b[3] = 32'hFFFFFFF8;  t2_p[3] = 64'd56;

        // Reset state
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_rsp_result", rsp_result, 64'd0);
        check("reset_ops_count", 64'(ops_count), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 2: 7 * -3
        set_req(2, 32'd7, 32'hFFFFFFFD);
        #1;
        check("single_grant", 64'(req_ready), 64'b0100);
        step();
        clr_req(2);
        #1;
        check("single_ready_after", 64'(req_ready), 64'd0);
        check("single_lat1_valid", 64'(rsp_valid), 64'd0);
        step();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        check("single_rsp_result", rsp_result, 64'hFFFFFFFFFFFFFFEB);
        step();
        check("single_ops_count", 64'(ops_count), 64'd1);
        check("single_rsp_drained", 64'(rsp_valid), 64'd0);

        // All four valid from reset: grants 0..3, back-to-back responses
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, t2_a[k], t2_b[k]);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 4) check($sformatf("all4_grant_%0d", c), 64'(req_ready), 64'(1 << c));
            if (c < 2) begin
                check($sformatf("all4_noresp_%0d", c), 64'(rsp_valid), 64'd0);
            end else begin
                check($sformatf("all4_valid_%0d", c - 2), 64'(rsp_valid), 64'd1);
                check($sformatf("all4_id_%0d", c - 2), 64'(rsp_id), 64'(c - 2));
                check($sformatf("all4_result_%0d", c - 2), rsp_result, t2_p[c-2]);
            end
            step();
            if (c < 4) clr_req(c);
        end
        check("all4_ops_count", 64'(ops_count), 64'd4);

        // Fairness: requesters 1 and 3 held valid continuously
        set_req(1, 32'd2, 32'd3);
        set_req(3, 32'd4, 32'd5);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("fair_grant_%0d", c), 64'(req_ready),
                  (c % 2 == 0) ? 64'b0010 : 64'b1000);
            if (c >= 2) begin
                check($sformatf("fair_rsp_id_%0d", c - 2), 64'(rsp_id),
                      (c % 2 == 0) ? 64'd1 : 64'd3);
            end
            step();
        end
        clr_req(1);
        clr_req(3);
        step();
        step();
        step();
        check("fair_ops_count", 64'(ops_count), 64'd10);

        // Backpressure with corner-case operands
        rsp_ready = 1'b0;
        set_req(0, 32'h80000000, 32'h80000000);
        set_req(1, 32'hFFFFFFFF, 32'h00000001);
        set_req(2, 32'h7FFFFFFF, 32'h80000000);
        #1;
        check("bp_grant0", 64'(req_ready), 64'b0001);
        step();
        clr_req(0);
        #1;
        check("bp_grant1", 64'(req_ready), 64'b0010);
        step();
        clr_req(1);
        #1;
        check("bp_full_ready", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bp_rsp_id", 64'(rsp_id), 64'd0);
        check("bp_rsp_result", rsp_result, 64'h4000000000000000);
        step();
        check("bp_hold_ready", 64'(req_ready), 64'd0);
        check("bp_hold_id", 64'(rsp_id), 64'd0);
        check("bp_hold_result", rsp_result, 64'h4000000000000000);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_grant2", 64'(req_ready), 64'b0100);
        step();
        clr_req(2);
        check("bp_drain1_id", 64'(rsp_id), 64'd1);
        check("bp_drain1_result", rsp_result, 64'hFFFFFFFFFFFFFFFF);
        step();
        check("bp_drain2_id", 64'(rsp_id), 64'd2);
        check("bp_drain2_result", rsp_result, 64'hC000000080000000);
        step();
        check("bp_drained", 64'(rsp_valid), 64'd0);
        check("bp_ops_count", 64'(ops_count), 64'd13);

        // Random operand pairs through requester 0
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            ea = longint'($signed(ra));
            eb = longint'($signed(rb));
            rexp = 64'(ea * eb);
            set_req(0, ra, rb);
            step();
            clr_req(0);
            step();
            check($sformatf("rand_%0d a=%h b=%h", i, ra, rb), rsp_result, rexp);
            step();
        end
        check("rand_ops_count", 64'(ops_count), 64'd113);

        // Reset mid-flight: fill S1 and S2 (grants 1 then 2, pointer left at 3)
        rsp_ready = 1'b0;
        set_req(1, 32'd9, 32'd9);
        #1;
        check("rst_fill_grant1", 64'(req_ready), 64'b0010);
        step();
        clr_req(1);
        set_req(2, 32'd8, 32'd8);
        #1;
        check("rst_fill_grant2", 64'(req_ready), 64'b0100);
        step();
        clr_req(2);
        check("rst_full_valid", 64'(rsp_valid), 64'd1);
        check("rst_full_id", 64'(rsp_id), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(rsp_valid), 64'd0);
        check("rst_async_ops", 64'(ops_count), 64'd0);
        check("rst_async_result", rsp_result, 64'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 32'd5, 32'd6);
        set_req(3, 32'd5, 32'd6);
        #1;
        check("rst_after_grant", 64'(req_ready), 64'b0010);
        check("rst_after_no_stale", 64'(rsp_valid), 64'd0);
        step();
        clr_req(1);
        clr_req(3);
        #1;
        check("rst_after_lat1", 64'(rsp_valid), 64'd0);
        step();
        check("rst_after_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rst_after_rsp_id", 64'(rsp_id), 64'd1);
        check("rst_after_rsp_result", rsp_result, 64'd30);
        step();
        check("rst_after_ops", 64'(ops_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
